// File: rtl/rf_pkg.sv
// Shared widths, constants and state encoding for the register-file write arbiter.
package rf_pkg;
  localparam int DATA_W   = 8;
  localparam int SEL_W    = 3;
  localparam int NUM_REGS = 8;

  localparam logic [SEL_W-1:0] DSEL_NOP   = 3'b000;
  localparam logic [SEL_W-1:0] DSEL_FIRST = 3'b001;
  localparam logic [SEL_W-1:0] DSEL_LAST  = SEL_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone eligible requester always wins; on a tie
// the requester that was not granted last wins.
module rr_arb2 (
  input  logic       elig0,
  input  logic       elig1,
  input  logic       last1,
  output logic [1:0] win
);
  always_comb begin
    win    = 2'b00;
    win[0] = elig0 & (~elig1 | last1);
    win[1] = elig1 & (~elig0 | ~last1);
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two register-file write requesters and runs a 7-cycle clear of R1..R7.
module rf_write_arbiter
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [SEL_W-1:0]  wsel0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [SEL_W-1:0]  wsel1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  input  logic              clr,
  output logic              busy,
  output logic [SEL_W-1:0]  dsel,
  output logic [DATA_W-1:0] rin
);
  state_e            state_q, state_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              busy_q, busy_d;
  logic              last1_q, last1_d;
  logic [SEL_W-1:0]  dsel_q, dsel_d;
  logic [DATA_W-1:0] rin_q, rin_d;
  logic              elig0, elig1;
  logic [1:0]        win;

  // A requester still seeing its grant this cycle must not be granted twice.
  assign elig0 = req0 & ~gnt0_q;
  assign elig1 = req1 & ~gnt1_q;

  rr_arb2 u_rr (
    .elig0 (elig0),
    .elig1 (elig1),
    .last1 (last1_q),
    .win   (win)
  );

  always_comb begin
    state_d = state_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = 1'b0;
    last1_d = last1_q;
    dsel_d  = DSEL_NOP;
    rin_d   = rin_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          dsel_d  = DSEL_FIRST;
          rin_d   = '0;
        end else if (win[0]) begin
          gnt0_d  = 1'b1;
          last1_d = 1'b0;
          dsel_d  = wsel0;
          rin_d   = wdata0;
        end else if (win[1]) begin
          gnt1_d  = 1'b1;
          last1_d = 1'b1;
          dsel_d  = wsel1;
          rin_d   = wdata1;
        end
      end
      ST_CLEAR: begin
        // dsel_q doubles as the clear counter; clr is ignored here.
        if (dsel_q == DSEL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
          dsel_d = dsel_q + 1'b1;
          rin_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      last1_q <= 1'b1;
      dsel_q  <= DSEL_NOP;
      rin_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      last1_q <= last1_d;
      dsel_q  <= dsel_d;
      rin_q   <= rin_d;
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
  assign dsel = dsel_q;
  assign rin  = rin_q;
endmodule
